// File: rtl/ula_sequencial.sv
// Multi-cycle ALU feeding the stack's ULA write port. Simple ops finish in one
// cycle; MUL (shift-add) and DIV (restoring) each take WIDTH sequential steps.
module ula_sequencial #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic [2*WIDTH-1:0] result,
  output logic               busy,
  output logic               done,
  output logic               div0
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state, state_nxt;
  logic [2:0]         op_r;
  logic [WIDTH-1:0]   a_r, b_r;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, acc_nxt, simple_res;
  logic               is_seq;

  logic [WIDTH:0]     mul_sum, rem_sh, rem_diff;
  logic               fits;

  assign is_seq = op[2] & op[1];

  always_comb begin
    simple_res = '0;
    case (op)
      OP_ADD:  simple_res = (2*WIDTH)'({1'b0, op_a} + {1'b0, op_b});
      OP_SUB:  simple_res = {{WIDTH{op_a < op_b}}, op_a - op_b};
      OP_AND:  simple_res = (2*WIDTH)'(op_a & op_b);
      OP_OR:   simple_res = (2*WIDTH)'(op_a | op_b);
      OP_XOR:  simple_res = (2*WIDTH)'(op_a ^ op_b);
      OP_NOT:  simple_res = (2*WIDTH)'(~op_a);
      default: simple_res = '0;
    endcase
  end

  // MUL: acc = {partial, multiplier}; DIV: acc = {remainder, dividend/quotient}
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_r} : '0);
    rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    fits     = rem_sh >= {1'b0, b_r};
    rem_diff = rem_sh - {1'b0, b_r};
    if (op_r == OP_MUL)
      acc_nxt = {mul_sum, acc[WIDTH-1:1]};
    else
      acc_nxt = {fits ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0], acc[WIDTH-2:0], fits};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = is_seq ? CALC : DONE;
      CALC:    if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      op_r   <= '0;
      a_r    <= '0;
      b_r    <= '0;
      cnt    <= '0;
      acc    <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      div0   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          op_r <= op;
          a_r  <= op_a;
          b_r  <= op_b;
          cnt  <= '0;
          div0 <= 1'b0;
          busy <= 1'b1;
          if (is_seq) begin
            acc <= (op == OP_MUL) ? {{WIDTH{1'b0}}, op_b} : {{WIDTH{1'b0}}, op_a};
          end else begin
            result <= simple_res;
            done   <= 1'b1;
          end
        end
        CALC: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            done <= 1'b1;
            if (op_r != OP_MUL && b_r == '0) begin
              result <= {a_r, {WIDTH{1'b1}}};
              div0   <= 1'b1;
            end else begin
              result <= acc_nxt;
            end
          end
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_sequencial.sv
// Directed plus randomized checks of ula_sequencial against an arithmetic model.
module tb_ula_sequencial;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [2:0]  op;
  logic [15:0] op_a, op_b;
  logic [31:0] result;
  logic        busy, done, div0;

  int checks = 0;
  int errors = 0;

  ula_sequencial #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
    .result(result), .busy(busy), .done(done), .div0(div0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] model(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
    int unsigned ua = a, ub = b;
    logic [31:0] r;
    logic        z = 1'b0;
    case (o)
      3'd0: r = ua + ub;
      3'd1: r = (ua < ub) ? (32'hFFFF0000 | ((ua - ub) & 32'hFFFF)) : ua - ub;
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: r = (~ua) & 32'hFFFF;
      3'd6: r = ua * ub;
      default: begin
        if (ub == 0) begin r = (ua << 16) | 32'hFFFF; z = 1'b1; end
        else r = ((ua % ub) << 16) | (ua / ub);
      end
    endcase
    return {z, r};
  endfunction

  // Runs one op; poke>0 presents an ADD start after that many edges since
  // the accept edge (counted from 1), which must be ignored.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [15:0] a,
                        input logic [15:0] b, input int poke);
    logic [32:0] exp = model(o, a, b);
    int lat_exp = (o >= 3'd6) ? 17 : 1;
    int c = 1;
    bit seen = 0;
    @(negedge clk);
    start = 1'b1; op = o; op_a = a; op_b = b;
    @(posedge clk);
    #1 start = 1'b0; op_a = 16'($urandom); op_b = 16'($urandom);
    while (c <= 40) begin
      @(negedge clk);
      if (c == poke) begin start = 1'b1; op = 3'd0; op_a = 16'($urandom); op_b = 16'($urandom); end
      else start = 1'b0;
      if (done) begin seen = 1; break; end
      @(posedge clk);
      c++;
    end
    check({tag, " done"}, 32'(seen), 32'd1);
    check({tag, " latency"}, c, lat_exp);
    check({tag, " result"}, result, exp[31:0]);
    check({tag, " div0"}, 32'(div0), 32'(exp[32]));
    check({tag, " busy@done"}, 32'(busy), 32'd1);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check({tag, " idle busy"}, 32'(busy), 32'd0);
    check({tag, " idle done"}, 32'(done), 32'd0);
    check({tag, " held"}, result, exp[31:0]);
  endtask

  initial begin
    int seen_done;
    rst = 1'b0; start = 1'b0; op = '0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("reset result", result, 32'h0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset div0", 32'(div0), 32'd0);

    run_op("add3+2", 3'd0, 16'd3, 16'd2, 0);
    check("add3+2 const", result, 32'h00000005);
    run_op("addcarry", 3'd0, 16'hFFFF, 16'h0001, 0);
    check("addcarry const", result, 32'h00010000);
    run_op("sub2-3", 3'd1, 16'd2, 16'd3, 0);
    check("sub2-3 const", result, 32'hFFFFFFFF);
    run_op("and", 3'd2, 16'hA5A5, 16'h0FF0, 0);
    check("and const", result, 32'h000005A0);
    run_op("mulmax", 3'd6, 16'hFFFF, 16'hFFFF, 5);
    check("mulmax const", result, 32'hFFFE0001);
    run_op("div100/7", 3'd7, 16'd100, 16'd7, 0);
    check("div100/7 const", result, 32'h0002000E);
    run_op("div5/0", 3'd7, 16'd5, 16'd0, 0);
    check("div5/0 const", result, 32'h0005FFFF);
    check("div5/0 flag", 32'(div0), 32'd1);
    run_op("add after div0", 3'd0, 16'd1, 16'd2, 0);
    check("div0 cleared", 32'(div0), 32'd0);
    // start presented in the cycle DONE exits must be dropped
    run_op("mul doneexit", 3'd6, 16'd300, 16'd7, 17);
    run_op("simple doneexit", 3'd3, 16'h1200, 16'h0034, 1);

    // abort a MUL mid-calculation
    @(negedge clk);
    start = 1'b1; op = 3'd6; op_a = 16'd3; op_b = 16'd4;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("abort result", result, 32'h0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort div0", 32'(div0), 32'd0);
    seen_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    check("abort no done", seen_done, 0);
    run_op("add1+1", 3'd0, 16'd1, 16'd1, 0);
    check("add1+1 const", result, 32'h00000002);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  ro = 3'($urandom);
      logic [15:0] ra = 16'($urandom);
      logic [15:0] rb = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      if ($urandom_range(0, 3) == 0) rb = 16'($urandom_range(1, 15));
      run_op($sformatf("rand%0d op%0d", i, ro), ro, ra, rb, ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 12)) : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
